// File: rtl/ds1302_burst_cmd_seq.sv
// DS1302 command sequencer: turns one clock/RAM burst command into byte accesses
// on the Access_Start_Sig/Access_Done_Sig handshake, with optional write-protect wrapping.
module ds1302_burst_cmd_seq #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned LEN_W   = 4,
    parameter bit          AUTO_WP = 1'b1
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             Cmd_Valid,
    output logic             Cmd_Ready,
    input  logic             Cmd_Write,
    input  logic             Cmd_Ram,
    input  logic [4:0]       Cmd_Addr,
    input  logic [LEN_W-1:0] Cmd_Len,
    output logic             Wr_Req,
    output logic [LEN_W-1:0] Wr_Idx,
    input  logic [7:0]       Wr_Data,
    output logic             Rd_Valid,
    output logic [LEN_W-1:0] Rd_Idx,
    output logic [7:0]       Rd_Data,
    output logic             Busy,
    output logic             Done_Sig,
    output logic [1:0]       Access_Start_Sig,
    input  logic             Access_Done_Sig,
    input  logic [7:0]       Read_Data,
    output logic [7:0]       Words_Addr,
    output logic [7:0]       Write_Data
);

    typedef enum logic [2:0] {
        S_IDLE, S_WP_OFF, S_LOAD, S_ACCESS, S_GAP, S_WP_ON, S_DONE
    } state_e;

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic             ready_q, ready_d;
    logic             write_q, write_d;
    logic             ram_q, ram_d;
    logic [4:0]       addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             wp_on_q, wp_on_d;
    logic [7:0]       words_addr_q, words_addr_d;
    logic [7:0]       write_data_q, write_data_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
    logic             rd_valid_q, rd_valid_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            write_q      <= 1'b0;
            ram_q        <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            wp_on_q      <= 1'b0;
            words_addr_q <= '0;
            write_data_q <= '0;
            rd_data_q    <= '0;
            rd_idx_q     <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            write_q      <= write_d;
            ram_q        <= ram_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            wp_on_q      <= wp_on_d;
            words_addr_q <= words_addr_d;
            write_data_q <= write_data_d;
            rd_data_q    <= rd_data_d;
            rd_idx_q     <= rd_idx_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        ram_d        = ram_q;
        addr_d       = addr_q;
        len_d        = len_q;
        idx_d        = idx_q;
        wp_on_d      = wp_on_q;
        words_addr_d = words_addr_q;
        write_data_d = write_data_q;
        rd_data_d    = rd_data_q;
        rd_idx_d     = rd_idx_q;
        rd_valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Cmd_Valid && ready_q) begin
                    write_d = Cmd_Write;
                    ram_d   = Cmd_Ram;
                    addr_d  = Cmd_Addr;
                    idx_d   = '0;
                    wp_on_d = 1'b0;
                    if (Cmd_Len == '0)
                        len_d = LEN_W'(1);
                    else if (Cmd_Len > MAX_LEN_W)
                        len_d = MAX_LEN_W;
                    else
                        len_d = Cmd_Len;
                    if (Cmd_Write && AUTO_WP) begin
                        state_d      = S_WP_OFF;
                        words_addr_d = 8'h8E;
                        write_data_d = 8'h00;
                    end else begin
                        state_d      = S_LOAD;
                        words_addr_d = {1'b1, Cmd_Ram, Cmd_Addr, ~Cmd_Write};
                    end
                end
            end
            S_WP_OFF, S_WP_ON: begin
                if (Access_Done_Sig) state_d = S_GAP;
            end
            S_LOAD: begin
                if (write_q) write_data_d = Wr_Data;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (Access_Done_Sig) begin
                    idx_d   = idx_q + LEN_W'(1);
                    addr_d  = addr_q + 5'd1;
                    state_d = S_GAP;
                    if (!write_q) begin
                        rd_data_d  = Read_Data;
                        rd_idx_d   = idx_q;
                        rd_valid_d = 1'b1;
                    end
                end
            end
            S_GAP: begin
                // wp_on_q marks that the closing WP-on access has already run
                if (wp_on_q) begin
                    state_d = S_DONE;
                end else if (idx_q < len_q) begin
                    state_d      = S_LOAD;
                    words_addr_d = {1'b1, ram_q, addr_q, ~write_q};
                end else if (write_q && AUTO_WP) begin
                    state_d      = S_WP_ON;
                    wp_on_d      = 1'b1;
                    words_addr_d = 8'h8E;
                    write_data_d = 8'h80;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        Access_Start_Sig = 2'b00;
        case (state_q)
            S_WP_OFF, S_WP_ON: Access_Start_Sig = 2'b10;
            S_ACCESS:          Access_Start_Sig = write_q ? 2'b10 : 2'b01;
            default:           Access_Start_Sig = 2'b00;
        endcase
    end

    assign Cmd_Ready  = ready_q;
    assign Busy       = (state_q != S_IDLE);
    assign Done_Sig   = (state_q == S_DONE);
    assign Wr_Req     = (state_q == S_LOAD) && write_q;
    assign Wr_Idx     = idx_q;
    assign Rd_Valid   = rd_valid_q;
    assign Rd_Idx     = rd_idx_q;
    assign Rd_Data    = rd_data_q;
    assign Words_Addr = words_addr_q;
    assign Write_Data = write_data_q;

endmodule
